// File: rtl/store_buffer_pkg.sv
// Shared types, default sizes and helpers for the write-behind store buffer.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 16;
    localparam int SB_DW    = 16;

    // One buffered store at the default widths.
    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sb_match.sv
// Store-to-load forwarding lookup: exact address compare against every
// occupied entry, youngest (closest behind the tail) wins.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW,
    localparam int PW   = clog2(DEPTH)
) (
    input  logic [AW-1:0]    addr_i,
    input  logic [AW-1:0]    ent_addr_i [DEPTH],
    input  logic [DW-1:0]    ent_data_i [DEPTH],
    input  logic [DEPTH-1:0] ent_valid_i,
    input  logic [PW-1:0]    tail_i,
    output logic             hit_o,
    output logic [DW-1:0]    hit_data_o
);

    logic [PW-1:0] idx;

    // Walk from oldest (tail-DEPTH) to youngest (tail-1) so later matches override.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        idx        = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail_i - PW'(k);
            if (ent_valid_i[idx] && (ent_addr_i[idx] == addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = ent_data_i[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Write-behind store buffer between the MEM stage and data memory. Stores are
// queued and drained on cycles the pipeline leaves the memory port idle;
// loads read memory directly with forwarding from buffered stores.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW,
    localparam int PW   = clog2(DEPTH),
    localparam int CW   = clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    input  logic          req_write_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          req_ready_o,
    output logic [DW-1:0] load_data_o,
    input  logic          drain_req_i,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_write_o,
    input  logic [DW-1:0] mem_rdata_i
);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             drain;
    logic             push;
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    off;
    logic             hit;
    logic [DW-1:0]    hit_data;

    assign full  = (count_q == CW'(DEPTH));
    // A store arriving at a full buffer forces the head out to make room.
    assign drain = (count_q != '0) &&
                   (drain_req_i || !req_valid_i || (full && req_valid_i && req_write_i));

    assign req_ready_o = !drain_req_i && !(full && req_write_i);
    // Push and drain are mutually exclusive: every drain cause either has no
    // valid request or deasserts req_ready.
    assign push        = req_valid_i && req_write_i && req_ready_o;

    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign mem_write_o = drain;
    assign mem_addr_o  = drain ? addr_q[head_q] : req_addr_i;
    assign mem_wdata_o = drain ? data_q[head_q] : req_wdata_i;
    assign load_data_o = hit ? hit_data : mem_rdata_i;

    // Entry i is occupied when its distance from the head is below count.
    always_comb begin
        valid = '0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = PW'(i) - head_q;
            valid[i] = (CW'(off) < count_q);
        end
    end

    sb_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_match (
        .addr_i      (req_addr_i),
        .ent_addr_i  (addr_q),
        .ent_data_i  (data_q),
        .ent_valid_i (valid),
        .tail_i      (tail_q),
        .hit_o       (hit),
        .hit_data_o  (hit_data)
    );

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) begin
            head_d  = head_q + PW'(1);
            count_d = count_q - CW'(1);
        end else if (push) begin
            tail_d  = tail_q + PW'(1);
            count_d = count_q + CW'(1);
        end
    end

    // Control state; reset discards buffered stores immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are meaningless until occupied, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[tail_q] <= req_addr_i;
            data_q[tail_q] <= req_wdata_i;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized + directed bench for store_buffer with a queue-based reference
// model and a scoreboard monitor sampling on the falling edge.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = SB_DEPTH;
    localparam int AW    = SB_AW;
    localparam int DW    = SB_DW;
    localparam int CW    = clog2(DEPTH) + 1;

    logic          clk, rst;
    logic          req_valid, req_write, req_ready, drain_req, empty;
    logic [AW-1:0] req_addr, mem_addr;
    logic [DW-1:0] req_wdata, load_data, mem_wdata, mem_rdata;
    logic [CW-1:0] count;
    logic          mem_write;

    logic [15:0] dmem    [0:255];
    logic [15:0] ref_mem [0:255];

    typedef struct {
        logic rdy;
        int   cnt;
        logic mw;
    } st_t;

    sb_entry_t   sbq [$];
    st_t         stq [$];
    sb_entry_t   wq  [$];
    logic [15:0] lq  [$];

    int total = 0;
    int bad   = 0;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_ready_o (req_ready),
        .load_data_o (load_data),
        .drain_req_i (drain_req),
        .empty_o     (empty),
        .count_o     (count),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_write_o (mem_write),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = dmem[mem_addr[7:0]];
    always @(posedge clk) if (mem_write) dmem[mem_addr[7:0]] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_load(input logic [15:0] a);
        for (int i = sbq.size() - 1; i >= 0; i--)
            if (sbq[i].addr == a) return sbq[i].data;
        return ref_mem[a[7:0]];
    endfunction

    // One cycle of stimulus: drive, predict, enqueue expectations, advance model.
    task automatic step(input logic v, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic dr, output logic acc);
        bit        full;
        logic      rdy, drn;
        st_t       s;
        sb_entry_t e;
        @(posedge clk);
        #1;
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        drain_req = dr;
        full  = (sbq.size() == DEPTH);
        rdy   = !dr && !(full && w);
        drn   = (sbq.size() > 0) && (dr || !v || (full && v && w));
        s.rdy = rdy;
        s.cnt = sbq.size();
        s.mw  = drn;
        stq.push_back(s);
        if (drn) wq.push_back(sbq[0]);
        if (v && !w && rdy) lq.push_back(model_load(a));
        acc = v && rdy;
        if (drn) begin
            ref_mem[sbq[0].addr[7:0]] = sbq[0].data;
            void'(sbq.pop_front());
        end else if (v && w && rdy) begin
            e.addr = a;
            e.data = d;
            sbq.push_back(e);
        end
    endtask

    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
        logic acc;
        acc = 1'b0;
        for (int n = 0; n < 10 && !acc; n++) step(1'b1, w, a, d, 1'b0, acc);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: request @%0h never accepted", a);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, acc);
    endtask

    // Scoreboard monitor.
    initial begin
        st_t         s;
        sb_entry_t   e;
        logic [15:0] x;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (stq.size() > 0) begin
                    s = stq.pop_front();
                    chk("req_ready", 32'(req_ready), 32'(s.rdy));
                    chk("count", 32'(count), 32'(s.cnt));
                    chk("empty", 32'(empty), 32'(s.cnt == 0));
                    chk("mem_write", 32'(mem_write), 32'(s.mw));
                end
                if (mem_write === 1'b1) begin
                    if (wq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL drain_unexpected: write @%0h data %0h with none expected", mem_addr, mem_wdata);
                    end else begin
                        e = wq.pop_front();
                        chk("drain_addr", 32'(mem_addr), 32'(e.addr));
                        chk("drain_data", 32'(mem_wdata), 32'(e.data));
                    end
                end
                if (req_valid && !req_write && req_ready) begin
                    if (lq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL load_unexpected: load @%0h accepted with none expected", req_addr);
                    end else begin
                        x = lq.pop_front();
                        chk("load_data", 32'(load_data), 32'(x));
                    end
                end
            end
        end
    end

    initial begin
        logic        acc, pend, hv, hw, dr;
        logic [15:0] ha, hd;
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = 16'(i * 8);
            ref_mem[i] = 16'(i * 8);
        end
        rst       = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'd2;
        req_wdata = 16'h0;
        drain_req = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_addr", 32'(mem_addr), 32'd2);
        chk("rst_load_data", 32'(load_data), 32'h0010);
        #1 rst = 1'b0;

        // Forward from a fresh store, then drain on idle.
        issue(1'b1, 16'd3, 16'hAAAA);
        issue(1'b0, 16'd3, 16'h0);
        chk("mem3_before_drain", 32'(dmem[3]), 32'h0018);
        idle(2);
        chk("mem3_after_drain", 32'(dmem[3]), 32'hAAAA);

        // Same-address stores stay separate; youngest forwarded.
        issue(1'b1, 16'd5, 16'h1111);
        issue(1'b1, 16'd5, 16'h2222);
        issue(1'b0, 16'd5, 16'h0);
        idle(3);
        chk("mem5_final", 32'(dmem[5]), 32'h2222);

        // Fill to full; the fifth store forces a head drain.
        for (int i = 0; i < 5; i++) issue(1'b1, 16'(i), 16'(16'h0100 + i));
        idle(1);

        // drain_req with three buffered and a pending load.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'd2, 16'h0, 1'b1, acc);
        step(1'b1, 1'b0, 16'd2, 16'h0, 1'b0, acc);
        step(1'b1, 1'b0, 16'd3, 16'h0, 1'b1, acc);
        step(1'b1, 1'b0, 16'd3, 16'h0, 1'b0, acc);

        // Reset while a drain is being presented.
        issue(1'b1, 16'd8, 16'hBEEF);
        issue(1'b1, 16'd9, 16'hCAFE);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #1;
        chk("pre_reset_drain", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_mem_write", 32'(mem_write), 32'd0);
        chk("async_rst_empty", 32'(empty), 32'd1);
        sbq.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        issue(1'b0, 16'd8, 16'h0);
        issue(1'b0, 16'd9, 16'h0);
        chk("mem8_after_reset", 32'(dmem[8]), 32'h0040);

        // Randomized traffic; a stalled request is held until accepted.
        pend = 1'b0;
        hv = 1'b0; hw = 1'b0; ha = 16'h0; hd = 16'h0;
        for (int n = 0; n < 400; n++) begin
            if (!pend) begin
                hv = ($urandom_range(0, 3) != 0);
                hw = 1'($urandom_range(0, 1));
                ha = 16'($urandom_range(0, 15));
                hd = 16'($urandom);
            end
            dr = ($urandom_range(0, 15) == 0);
            step(hv, hw, ha, hd, dr, acc);
            pend = hv && !acc;
        end

        for (int n = 0; n < 12 && sbq.size() > 0; n++) idle(1);
        idle(2);
        @(negedge clk);
        #1;
        chk("status_queue_drained", 32'(stq.size()), 32'd0);
        chk("write_queue_drained", 32'(wq.size()), 32'd0);
        chk("load_queue_drained", 32'(lq.size()), 32'd0);
        for (int i = 0; i < 16; i++) chk($sformatf("final_mem[%0d]", i), 32'(dmem[i]), 32'(ref_mem[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-behind store buffer between the EX/MEM pipeline register and the data memory. It queues stores in a small FIFO and drains them into memory on cycles when the pipeline leaves the memory port idle. Loads read memory directly, and matching buffered stores are forwarded to them, so the pipeline sees memory-consistent data. It drives the data memory's `Address`/`WriteData`/`memWrite` inputs and consumes its combinational `ReadData`.

## Interface
- `DEPTH`, 4: number of buffered stores (power of two, ≥2)
- `AW`, 16: address width
- `DW`, 16: data width
- `clk` input 1: clock, rising edge
- `rst` input 1: reset, asynchronous, active-high
- `req_valid` input 1: MEM-stage memory request this cycle
- `req_write` input 1: 1 = store, 0 = load (qualified by `req_valid`)
- `req_addr` input AW: request address
- `req_wdata` input DW: store data
- `req_ready` output 1: request accepted this cycle; 0 = pipeline must stall and hold the request
- `load_data` output DW: load result, combinational, valid when `req_valid & !req_write & req_ready`
- `drain_req` input 1: force full drain (halt/fence)
- `empty` output 1: buffer holds no stores
- `count` output $clog2(DEPTH)+1: occupancy
- `mem_addr` output AW: to data memory `Address`
- `mem_wdata` output DW: to data memory `WriteData`
- `mem_write` output 1: to data memory `memWrite`
- `mem_rdata` input DW: from data memory `ReadData` (combinational read)

## Operation
- Storage: circular FIFO of {addr, data} entries, head/tail pointers, `count` register.
- Drain condition `drain = (count>0) & (drain_req | !req_valid | (full & req_valid & req_write))`.
- While `drain` is high: `mem_addr` = head addr, `mem_wdata` = head data, `mem_write` = 1. The head pops at the clock edge.
- While `drain` is low: `mem_addr` = `req_addr`, `mem_write` = 0, `mem_wdata` = `req_wdata` (don't-care).
- Store acceptance: `req_ready = !drain_req & !(full & req_write)` for any valid request. An accepted store pushes at the tail.
- Full plus store: forced drain of the head that cycle, with `req_ready=0`. The store is accepted the next cycle with count DEPTH-1.
- Load: `load_data` = data of the youngest entry whose addr equals `req_addr`, otherwise `mem_rdata`. The address compare is exact, on the full AW bits.
- A load never coincides with a drain. No load-versus-draining-entry race exists.
- `drain_req`: stalls all requests (`req_ready=0`) and drains one entry per cycle until `empty`. With the buffer empty, `req_ready` stays 0 while `drain_req` is high.
- Same-address stores are kept as separate entries, in program order. There is no coalescing.
- Simultaneous push and pop is impossible by construction. Push requires a valid request that is not forced; pop requires idle, forced-full, or `drain_req`, and forced-full blocks the push.

## Timing
- Reset (async, on `rst` high): head = tail = 0, `count`=0, `empty`=1. Outputs: `req_ready`=1 (when `drain_req`=0), `mem_write`=0, `mem_addr`=`req_addr`, `load_data`=`mem_rdata`.
- Reset mid-drain: buffered stores are discarded. Memory contents already written remain.
- A store accepted at edge N is forwardable to loads from cycle N+1. It reaches memory at the first drain edge after it becomes head.
- Load latency 0 cycles. The result is combinational in the same cycle.
- Drain throughput: 1 entry per idle cycle.
- Pointer wrap: modulo DEPTH. Full is `count==DEPTH`.

## Structure
- Shared package `store_buffer_pkg`:
  - default AW/DW/DEPTH constants
  - `sb_entry_t` {addr, data}
  - `clog2` helper
- Sub-module `sb_match`: parallel address compare across all valid entries, with youngest-first priority select relative to the tail. Outputs `hit` and `hit_data`.

## Test plan
- Reset, then load addr 2 with memory[2]=0x0010 → `load_data`=0x0010, `mem_write`=0, `count`=0, `empty`=1.
- Store 0xAAAA@3, then load @3 next cycle (no idle) → `load_data`=0xAAAA while memory[3] is unchanged. Idle cycle → `mem_write`=1, `mem_addr`=3, memory[3]=0xAAAA, `count`=0.
- Stores 0x1111@5 then 0x2222@5, then load @5 → `load_data`=0x2222 (youngest). Two idle cycles → memory[5] written 0x1111, then 0x2222.
- Back-to-back stores to addrs 0..4 with DEPTH=4 → 5th store sees `req_ready`=0 for one cycle, memory[0] written that cycle, store @4 accepted the next cycle, `count`=4.
- `drain_req` high with `count`=3 and a pending load → `req_ready`=0 for 3 cycles, 3 memory writes in FIFO order, then `empty`=1. Load accepted the cycle `drain_req` drops.
- `rst` asserted with `count`=2 mid-drain → `count`=0, `mem_write`=0 immediately, without waiting for a clock edge. Later loads of the un-drained addresses return the old memory values.
